// File: rtl/hard_grand.sv
`default_nettype none
// ============================================================================
// hard_grand : sequential hard-decision GRAND decoder for the (8,4) d=4 code.
// Revision   : 1.0
// ============================================================================
module hard_grand #(
    parameter int N         = 8,
    parameter int MAX_GUESS = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:N-1] cHat,
    output logic [0:N-1] c,
    output logic         done,
    output logic [5:0]   guesses
);

    // The code is self-dual, so these rows serve as both H and G.
    localparam logic [0:7] H0 = 8'b00010111;
    localparam logic [0:7] H1 = 8'b00101011;
    localparam logic [0:7] H2 = 8'b10100101;
    localparam logic [0:7] H3 = 8'b11000011;

    logic [0:7] chat_q;
    logic [5:0] idx;
    logic       loaded;

    logic [0:7] pattern;
    logic [0:7] cand;
    logic [3:0] syndrome;

    // Guess order: no flip, singles left to right, then doubles by widest
    // separation first with ties broken by the lower left index.
    function automatic logic [0:7] pattern_of(input logic [5:0] k);
        logic [0:7] p;
        int         n;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (k == 6'(i + 1)) p[i] = 1'b1;
        end
        n = 9;
        for (int d = 7; d >= 1; d--) begin
            for (int i = 0; i + d < 8; i++) begin
                if (k == 6'(n)) begin
                    p[i]     = 1'b1;
                    p[i + d] = 1'b1;
                end
                n++;
            end
        end
        return p;
    endfunction

    always_comb begin
        pattern  = pattern_of(idx);
        cand     = chat_q ^ pattern;
        syndrome = {^(cand & H3), ^(cand & H2), ^(cand & H1), ^(cand & H0)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chat_q  <= '0;
            idx     <= '0;
            loaded  <= 1'b0;
            c       <= '0;
            done    <= 1'b0;
            guesses <= '0;
        end else if (!loaded || (cHat != chat_q)) begin
            chat_q <= cHat;
            idx    <= '0;
            done   <= 1'b0;
            loaded <= 1'b1;
        end else if (!done) begin
            if (idx >= 6'(MAX_GUESS)) begin
                c       <= chat_q;
                guesses <= 6'(MAX_GUESS);
                done    <= 1'b1;
            end else if (syndrome == 4'd0) begin
                c       <= cand;
                guesses <= idx + 6'd1;
                done    <= 1'b1;
            end else begin
                idx <= idx + 6'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hard_grand.sv
`default_nettype none
// Testbench for hard_grand: directed and random words against a list-search model.
module tb_hard_grand;

    logic       clk;
    logic       rst;
    logic [7:0] chat;
    logic [7:0] c;
    logic       done;
    logic [5:0] guesses;

    int n_checks = 0;
    int n_errors = 0;

    bit         is_cw [256];
    logic [7:0] pats  [37];

    logic [7:0] exp_c;
    logic [7:0] cur_word;
    bit         cur_valid;

    hard_grand dut (
        .clk     (clk),
        .rst     (rst),
        .cHat    (chat),
        .c       (c),
        .done    (done),
        .guesses (guesses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Bit i (leftmost = 0) of a word is numeric weight 1 << (7 - i).
    function automatic logic [7:0] bit_of(input int i);
        return 8'(1 << (7 - i));
    endfunction

    task automatic build_model();
        logic [7:0] rows [4];
        int         keys [$];
        logic [7:0] w;
        int         sep, i;
        rows[0] = 8'b00010111;
        rows[1] = 8'b00101011;
        rows[2] = 8'b10100101;
        rows[3] = 8'b11000011;
        for (int v = 0; v < 256; v++) is_cw[v] = 1'b0;
        for (int m = 0; m < 16; m++) begin
            w = '0;
            for (int r = 0; r < 4; r++) if (m[r]) w = w ^ rows[r];
            is_cw[w] = 1'b1;
        end
        pats[0] = '0;
        for (int b = 0; b < 8; b++) pats[1 + b] = bit_of(b);
        for (int a = 0; a < 8; a++)
            for (int b = a + 1; b < 8; b++)
                keys.push_back((7 - (b - a)) * 8 + a);
        keys.sort();
        for (int k = 0; k < 28; k++) begin
            sep = 7 - keys[k] / 8;
            i   = keys[k] % 8;
            pats[9 + k] = bit_of(i) | bit_of(i + sep);
        end
    endtask

    task automatic ref_decode(input logic [7:0] r, output logic [7:0] cw, output int g);
        cw = r;
        g  = 37;
        for (int k = 36; k >= 0; k--) begin
            if (is_cw[r ^ pats[k]]) begin
                cw = r ^ pats[k];
                g  = k + 1;
            end
        end
    endtask

    task automatic run_word(input string tag, input logic [7:0] w);
        logic [7:0] cw;
        int         g, exp_cyc, cyc;
        ref_decode(w, cw, g);
        exp_cyc = (cur_valid && w == cur_word) ? 1 : g + 1;
        chat = w;
        cyc  = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1 && exp_cyc > 1) check({tag, "_hold_c"}, 32'(c), 32'(exp_c));
        end while (!done && cyc < 80);
        check({tag, "_latency"}, cyc, exp_cyc);
        check({tag, "_c"}, 32'(c), 32'(cw));
        check({tag, "_guesses"}, 32'(guesses), g);
        exp_c     = cw;
        cur_word  = w;
        cur_valid = 1'b1;
    endtask

    initial begin
        logic [7:0] w;
        build_model();
        rst       = 1'b1;
        chat      = '0;
        exp_c     = '0;
        cur_word  = '0;
        cur_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_c", 32'(c), 0);
        check("reset_done", 32'(done), 0);
        check("reset_guesses", 32'(guesses), 0);
        rst = 1'b0;

        run_word("codeword", 8'b00010111);
        run_word("single_a", 8'b01000000);
        run_word("single_b", 8'b10100100);
        run_word("single_c", 8'b00100011);
        run_word("single_d", 8'b00001101);
        run_word("double_a", 8'b01000100);
        run_word("double_b", 8'b10000111);
        run_word("double_c", 8'b00001001);

        // Same word twice: no restart, result held.
        run_word("repeat1", 8'b01010111);
        chat = 8'b01010111;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("repeat_done", 32'(done), 1);
            check("repeat_c", 32'(c), 32'(8'b00010111));
        end
        run_word("repeat2", 8'b00010111);

        // Abort a search two cycles after its load.
        chat = 8'b00001001;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_done", 32'(done), 0);
            check("abort_hold", 32'(c), 32'(exp_c));
        end
        chat = 8'b01000000;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort2_done", 32'(done), 0);
            check("abort2_hold", 32'(c), 32'(exp_c));
        end
        @(posedge clk);
        #1;
        check("abort_new_done", 32'(done), 1);
        check("abort_new_c", 32'(c), 0);
        check("abort_new_guesses", 32'(guesses), 3);
        exp_c    = 8'h00;
        cur_word = 8'b01000000;

        // Asynchronous reset in the middle of a long search.
        chat = 8'b01000100;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_c", 32'(c), 0);
        check("async_done", 32'(done), 0);
        check("async_guesses", 32'(guesses), 0);
        #1;
        rst       = 1'b0;
        exp_c     = '0;
        cur_valid = 1'b0;
        run_word("after_reset", 8'b01000100);

        for (int t = 0; t < 150; t++) begin
            w = ($urandom_range(0, 7) == 0) ? cur_word : 8'($urandom_range(0, 255));
            run_word("random", w);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hard_grand.md
Name: hard_grand

Overview:
- Sequential hard-decision GRAND (Guessing Random Additive Noise Decoding) decoder for a fixed (8,4) linear block code with minimum distance 4.
- Sits after the hard-slicer in the receive path. It takes an 8-bit received word `cHat` and tests noise patterns in a fixed likelihood order, one pattern per clock.
- The first pattern e for which `cHat`^e is a codeword produces the corrected output `c`.
- The code has covering radius 2, so every search ends by weight 2 (at most 37 guesses).

Parameters:
- N, 8, codeword length; fixed, not overridable in practice.
- MAX_GUESS, 37, guess-index bound (1 + 8 + 28 patterns of weight 0..2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- cHat  input  [0:7]  received hard-decision word; bit 0 is the leftmost/MSB.
- c  output  [0:7]  decoded codeword.
- done  output  1  high while `c` holds the decode of the current latched word.
- guesses  output  6  number of patterns tested to reach the current result (1..37).

Behaviour:
- Bit numbering: index 0 is leftmost. Pattern {i,j} means bits i and j flipped.
- Parity-check matrix H has 4 rows. The code is self-dual, so H is also the generator.
  - h0 = 00010111
  - h1 = 00101011
  - h2 = 10100101
  - h3 = 11000011
- Syndrome s_r = XOR-reduce(x & h_r). x is a codeword iff all four s_r = 0.
- Guess order (index k), total order fixed:
  - k=0: no flip.
  - k=1..8: single flips of bit 0,1,...,7.
  - k=9..36: double flips {i,j}, i<j, sorted by separation (j-i) descending from 7 to 1. Ties are broken by ascending i.
  - The double-flip sequence starts {0,7},{0,6},{1,7},{0,5},{1,6},{2,7},{0,4},{1,5},{2,6},{3,7},... and ends {6,7}.
- Registers:
  - `chat_q` [0:7] latches the word being decoded.
  - `idx` [5:0] is the current guess index.
  - `loaded` is a flag.
  - `c`, `done`, `guesses` are registered outputs.
- Reset (async assert): `c`=0, `done`=0, `guesses`=0, `idx`=0, `chat_q`=0, `loaded`=0.
- Each rising edge, in priority order:
  1. If `loaded`=0 or `cHat` != `chat_q`: `chat_q`<=`cHat`, `idx`<=0, `done`<=0, `loaded`<=1. `c` and `guesses` keep their old values.
  2. Else if `done`=0: form x = `chat_q` ^ pattern(`idx`).
     - If the syndrome of x is zero: `c`<=x, `guesses`<=`idx`+1, `done`<=1.
     - Otherwise: `idx`<=`idx`+1.
  3. Else (`done`=1): hold all state.
- Latency: a word needing guess k sets `done` k+1 cycles after the load edge. Worst case is 37 cycles.
- Defensive guard: if `idx` reaches MAX_GUESS without success, set `done`=1, `c`=`chat_q`, `guesses`=37. This is unreachable for this code.
- A change of `cHat` mid-search aborts the search and restarts from k=0 on that edge. `c` keeps the previous result until the new `done`.
- Reset released mid-operation: decoding restarts from k=0 with the current `cHat` on the first edge.
- Pattern generation is a combinational lookup from `idx`.

Test Plan:
- Reset, then `cHat`=00010111 (codeword): after 2 edges `done`=1, `c`=00010111, `guesses`=1.
- Single errors:
  - `cHat`=01000000 -> `c`=00000000, `guesses`=3.
  - `cHat`=10100100 -> `c`=10100101.
  - `cHat`=00100011 -> `c`=00101011.
  - `cHat`=00001101 -> `c`=01001101.
- Double-error tie-break, with candidate flips {0,3},{1,5},{2,6},{4,7} each valid; {1,5} must win, `guesses`=17:
  - `cHat`=01000100 -> `c`=00000000.
  - `cHat`=10000111 -> `c`=11000011.
  - `cHat`=00001001 -> `c`=01001101.
- Back-to-back identical words (01010111 twice): the second does not restart, `done` stays 1, `c`=00010111. Then 00010111 -> restart and same `c`.
- Change `cHat` from 00001001 to 01000000 two cycles after load: `done` stays low, old `c` is held, new result `c`=00000000 after 3 further cycles.
- Assert `rst` mid-search: `c`=0 and `done`=0 immediately (asynchronous); after release the decode restarts and completes correctly.
